// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the direct-mapped instruction cache.
// Field widths derive from the line geometry so the top and the fill FSM stay in sync.
package icache_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    function automatic int off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int addr_w, input int lines, input int line_words);
        return addr_w - 2 - off_w(line_words) - idx_w(lines);
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch port plus backing-memory port of the instruction cache.
// The slave side is the cache; the master side is the core and memory environment.
interface icache_if
    import icache_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic              instrreq;
    logic [ADDR_W-1:0] instradr;
    logic [WORD_W-1:0] instr;
    logic              hit;
    logic              abort;
    logic              inv;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  instrreq, instradr, inv, mem_rdata, mem_ack,
        output instr, hit, abort, mem_req, mem_addr
    );

    modport master (
        output instrreq, instradr, inv, mem_rdata, mem_ack,
        input  instr, hit, abort, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_fill_fsm.sv
// Line-fill sequencer: bursts words 0..LINE_WORDS-1 from memory after a miss.
// mem_req/mem_addr/abort are registered; cancel is only honoured on an ack cycle.
module icache_fill_fsm
    import icache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_instrreq,
    input  logic [ADDR_W-1:0]             i_instradr,
    input  logic                          i_hit,
    input  logic                          i_inv,
    input  logic                          i_mem_ack,
    output logic                          o_mem_req,
    output logic [ADDR_W-1:0]             o_mem_addr,
    output logic                          o_abort,
    output logic                          o_wr_en,
    output logic                          o_wr_last,
    output logic [$clog2(LINE_WORDS)-1:0] o_wc,
    output logic [ADDR_W-1:0]             o_fill_addr
);
    localparam int OB  = off_w(LINE_WORDS);
    localparam int LSB = OB + 2;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((64'd1 << LSB) - 64'd1);

    state_t            r_state;
    logic [OB-1:0]     r_wc;
    logic [ADDR_W-1:0] r_fill_addr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_req;
    logic              r_abort;

    logic [ADDR_W-1:0] w_line_addr;
    logic [OB-1:0]     w_wc_next;
    logic              w_last;
    logic              w_cancel;
    logic              w_ack;

    assign w_line_addr = i_instradr & LINE_MASK;
    assign w_wc_next   = r_wc + 1'b1;
    assign w_last      = (r_wc == OB'(LINE_WORDS - 1));
    assign w_cancel    = !i_instrreq || (w_line_addr != r_fill_addr) || i_inv;
    assign w_ack       = (r_state == S_FILL) && i_mem_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wc        <= '0;
            r_fill_addr <= '0;
            r_mem_addr  <= '0;
            r_mem_req   <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_abort <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_instrreq && !i_hit && !i_inv) begin
                        r_state     <= S_FILL;
                        r_fill_addr <= w_line_addr;
                        r_wc        <= '0;
                        r_mem_req   <= 1'b1;
                        r_mem_addr  <= w_line_addr;
                    end
                end
                S_FILL: begin
                    if (i_mem_ack) begin
                        r_wc <= w_wc_next;
                        if (w_last) begin
                            r_state   <= S_IDLE;
                            r_mem_req <= 1'b0;
                        end else if (w_cancel) begin
                            // Partial line is abandoned; the top keeps it invalid.
                            r_state   <= S_IDLE;
                            r_mem_req <= 1'b0;
                            r_abort   <= 1'b1;
                        end else begin
                            r_mem_addr <= r_fill_addr | ADDR_W'({w_wc_next, 2'b00});
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_mem_req   = r_mem_req;
    assign o_mem_addr  = r_mem_addr;
    assign o_abort     = r_abort;
    assign o_wr_en     = w_ack;
    assign o_wr_last   = w_ack && w_last;
    assign o_wc        = r_wc;
    assign o_fill_addr = r_fill_addr;

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache; hit/instr are combinational (0-cycle hit).
// Misses stall the fetch until a LINE_WORDS burst fills the line from backing memory.
module icache
    import icache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic    clk,
    input  logic    reset,
    icache_if.slave bus
);
    localparam int OB  = off_w(LINE_WORDS);
    localparam int IB  = idx_w(LINES);
    localparam int TB  = tag_w(ADDR_W, LINES, LINE_WORDS);
    localparam int LSB = OB + 2;

    logic              r_valid [LINES];
    logic [TB-1:0]     r_tag   [LINES];
    logic [WORD_W-1:0] r_data  [LINES][LINE_WORDS];

    logic [OB-1:0]     w_off;
    logic [IB-1:0]     w_idx;
    logic [TB-1:0]     w_tag;
    logic [ADDR_W-1:0] w_fill_addr;
    logic [IB-1:0]     w_fill_idx;
    logic [TB-1:0]     w_fill_tag;
    logic [OB-1:0]     w_wc;
    logic              w_wr_en;
    logic              w_wr_last;
    logic              w_unused;

    assign w_off      = bus.instradr[OB+1:2];
    assign w_idx      = bus.instradr[LSB+IB-1:LSB];
    assign w_tag      = bus.instradr[ADDR_W-1:LSB+IB];
    assign w_fill_idx = w_fill_addr[LSB+IB-1:LSB];
    assign w_fill_tag = w_fill_addr[ADDR_W-1:LSB+IB];
    assign w_unused   = &{1'b0, bus.instradr[1:0], w_fill_addr[LSB-1:0]};

    assign bus.hit   = bus.instrreq && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign bus.instr = r_data[w_idx][w_off];

    icache_fill_fsm #(
        .ADDR_W     (ADDR_W),
        .LINE_WORDS (LINE_WORDS)
    ) u_fill (
        .clk         (clk),
        .reset       (reset),
        .i_instrreq  (bus.instrreq),
        .i_instradr  (bus.instradr),
        .i_hit       (bus.hit),
        .i_inv       (bus.inv),
        .i_mem_ack   (bus.mem_ack),
        .o_mem_req   (bus.mem_req),
        .o_mem_addr  (bus.mem_addr),
        .o_abort     (bus.abort),
        .o_wr_en     (w_wr_en),
        .o_wr_last   (w_wr_last),
        .o_wc        (w_wc),
        .o_fill_addr (w_fill_addr)
    );

    // The line being overwritten drops valid on its first word so stale data never hits.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LINES; i++) r_valid[i] <= 1'b0;
        end else if (bus.inv) begin
            for (int i = 0; i < LINES; i++) r_valid[i] <= 1'b0;
        end else if (w_wr_en) begin
            r_valid[w_fill_idx] <= w_wr_last;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_last) r_tag[w_fill_idx] <= w_fill_tag;
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_data[w_fill_idx][w_wc] <= bus.mem_rdata;
    end

endmodule
